// File: rtl/debug_pattern_generator_2.sv
// rtl/debug_pattern_generator_2.sv - colour-bar test pattern source feeding a downstream pixel FIFO
module debug_pattern_generator_2 #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en,
    output logic        queue_wr_clk
);

    localparam int BAR_WIDTH = FRAME_WIDTH / 10;
    localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] LAST_ROW = 11'(FRAME_HEIGHT - 1);

    localparam logic [15:0] BAR_COLOUR [10] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
        16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFD20
    };

    logic [10:0] col_q, col_d;
    logic [10:0] row_q, row_d;
    logic        run_q, run_d;
    logic [15:0] pixel;

    assign queue_wr_clk = clk;
    assign queue_wr_en  = run_q & ~queue_full;
    assign queue_data   = {(col_q == 11'd0) && (row_q == 11'd0), pixel};

    // Scan from the right so the lowest matching bar wins; columns past the
    // last whole bar keep the black default.
    always_comb begin
        pixel = 16'h0000;
        for (int i = 9; i >= 0; i--) begin
            if (int'(col_q) < (i + 1) * BAR_WIDTH) begin
                pixel = BAR_COLOUR[i];
            end
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        run_d = 1'b1;
        if (queue_wr_en) begin
            if (col_q == LAST_COL) begin
                col_d = 11'd0;
                row_d = (row_q == LAST_ROW) ? 11'd0 : row_q + 11'd1;
            end else begin
                col_d = col_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= 11'd0;
            row_q <= 11'd0;
            run_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            run_q <= run_d;
        end
    end

endmodule

// File: tb/tb_debug_pattern_generator_2.sv
// tb/tb_debug_pattern_generator_2.sv - randomized/directed bench with a pixel-index reference model
module tb_debug_pattern_generator_2;

    localparam int W  = 640;
    localparam int H  = 20;
    localparam int FP = W * H;
    localparam int BW = W / 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        queue_full;
    logic [16:0] queue_data;
    logic        queue_wr_en;
    logic        queue_wr_clk;

    int tests = 0;
    int fails = 0;

    int idx;
    bit run_exp;
    int writes;
    int markers;
    int last_col;
    logic [16:0] last_data;
    int marker_pos [$];

    debug_pattern_generator_2 #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .queue_full  (queue_full),
        .queue_data  (queue_data),
        .queue_wr_en (queue_wr_en),
        .queue_wr_clk(queue_wr_clk)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] colour_of(input int c);
        int bar;
        bar = c / BW;
        case (bar)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            7: return 16'h0000;
            8: return 16'h8410;
            9: return 16'hFD20;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [16:0] word_of(input int n);
        return {n == 0, colour_of(n % W)};
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic qf);
        logic exp_wr;
        @(negedge clk);
        queue_full = qf;
        #1;
        exp_wr = run_exp && !qf;
        chk("wr_en", {16'b0, queue_wr_en}, {16'b0, exp_wr});
        chk("data", queue_data, word_of(idx));
        if (exp_wr) begin
            writes++;
            if (queue_data[16]) begin
                markers++;
                marker_pos.push_back(writes);
            end
            last_col  = idx % W;
            last_data = queue_data;
            idx = (idx + 1) % FP;
        end
        run_exp = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("wr_en_after_release", {16'b0, queue_wr_en}, 17'd0);
        chk("data_after_release", queue_data, 17'h1FFFF);
        idx = 0;
        run_exp = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        queue_full = 1'b0;
        idx = 0;
        run_exp = 1'b0;
        writes = 0;
        markers = 0;
        last_col = -1;
        last_data = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_wr_en", {16'b0, queue_wr_en}, 17'd0);
        chk("reset_data", queue_data, 17'h1FFFF);
        chk("wr_clk_hi", {16'b0, queue_wr_clk}, {16'b0, clk});
        release_reset();

        // One full frame plus the first pixel of the next, never full.
        step(1'b0);
        chk("first_word", last_data, 17'h1FFFF);
        for (int n = 1; n < FP + 1; n++) begin
            step(1'b0);
            if (writes <= W && last_col == 63)  chk("col63", last_data, 17'h0FFFF);
            if (writes <= W && last_col == 64)  chk("col64", last_data, 17'h0FFE0);
            if (writes <= W && last_col == 639) chk("col639", last_data, 17'h0FD20);
            if (writes == FP && last_col == 639) chk("col639_last_row", last_data, 17'h0FD20);
        end
        chk("frame_writes", 17'(writes), 17'(FP + 1));
        chk("marker_count", 17'(markers), 17'd2);
        if (marker_pos.size() == 2) begin
            chk("marker_pos0", 17'(marker_pos[0]), 17'd1);
            chk("marker_pos1", 17'(marker_pos[1]), 17'(FP + 1));
        end
        chk("write_12801", last_data, 17'h1FFFF);

        // Run to column 100 of the current row, then stall 50 cycles.
        for (int n = 0; n < 2 * W && (idx % W) != 100; n++) step(1'b0);
        chk("reached_col100", 17'(idx % W), 17'd100);
        repeat (50) step(1'b1);
        step(1'b0);
        chk("resume_col", 17'(last_col), 17'd100);
        chk("resume_data", last_data, 17'h0FFE0);

        // Toggle full every cycle for a whole frame's worth of writes.
        writes = 0;
        for (int n = 0; n < 2 * FP; n++) step(n[0]);
        chk("toggle_writes", 17'(writes), 17'(FP));

        // Random backpressure.
        for (int n = 0; n < 3000; n++) step(1'($urandom_range(0, 2) == 0));

        // Run to row 5, column 300 of a frame then reset asynchronously.
        for (int n = 0; n < 2 * FP && idx != 5 * W + 300; n++) step(1'($urandom_range(0, 3) == 0));
        chk("reached_r5c300", 17'(idx), 17'(5 * W + 300));
        @(negedge clk);
        queue_full = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("midframe_reset_wr_en", {16'b0, queue_wr_en}, 17'd0);
        chk("midframe_reset_data", queue_data, 17'h1FFFF);
        run_exp = 1'b0;
        release_reset();
        step(1'b0);
        chk("restart_word", last_data, 17'h1FFFF);
        for (int n = 0; n < 1500; n++) step(1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
